// File: rtl/aes_key_expander.sv
// AES-128 key expander: expands the cipher key into 44 words (11 round keys),
// one word per cycle, and serves any round key through a combinational read port.
module aes_key_expander #(
  parameter int REVERSE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         key_ready
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t      state, state_nxt;
  logic [31:0] w [44];
  logic [5:0]  cnt;
  logic        load;
  logic [31:0] prev, rot, sub, tmp, new_word;
  logic [3:0]  k;
  logic [5:0]  base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    key_ready = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        if (cnt == 6'd43) state_nxt = DONE;
      end
      DONE: begin
        key_ready = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next word: cnt is always 4..43 while expanding, so both taps are in range.
  always_comb begin
    prev = w[cnt - 6'd1];
    rot  = {prev[23:0], prev[31:24]};
    sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    if (cnt[1:0] == 2'b00) tmp = sub ^ {rcon(cnt[5:2]), 24'h0};
    else                   tmp = prev;
    new_word = w[cnt - 6'd4] ^ tmp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 44; j++) w[j] <= '0;
      cnt <= '0;
    end else if (load) begin
      w[0] <= key_in[127:96];
      w[1] <= key_in[95:64];
      w[2] <= key_in[63:32];
      w[3] <= key_in[31:0];
      cnt  <= 6'd4;
    end else if (state == EXPAND) begin
      w[cnt] <= new_word;
      if (cnt != 6'd43) cnt <= cnt + 6'd1;
    end
  end

  always_comb begin
    k      = (REVERSE != 0) ? (4'd10 - rd_round) : rd_round;
    base   = {k, 2'b00};
    rd_key = '0;
    if (rd_round <= 4'd10)
      rd_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: forward and reverse instances checked
// against an FIPS-197 key schedule model built from GF(2^8) arithmetic.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rd_round, rd_round_m, rd_round_r;
  logic         rst_chk;
  logic [127:0] rd_key_f, rd_key_r;
  logic         busy_f, busy_r, key_ready_f, key_ready_r;

  assign rd_round = rst_chk ? rd_round_r : rd_round_m;

  aes_key_expander #(.REVERSE(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rd_round(rd_round),
    .rd_key(rd_key_f), .busy(busy_f), .key_ready(key_ready_f));

  aes_key_expander #(.REVERSE(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rd_round(rd_round),
    .rd_key(rd_key_r), .busy(busy_r), .key_ready(key_ready_r));

  always #20 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1407:0] rk;
    int unsigned   rcyc;
  } exp_t;
  exp_t q[$];

  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model(input logic [127:0] key, output logic [1407:0] rk);
    logic [31:0] mw [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int j = 0; j < 4; j++) mw[j] = key[127 - 32*j -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = mw[i-1];
      if (i % 4 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      mw[i] = mw[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r*128 +: 128] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, want);
    end
  endtask

  task automatic do_start(input logic [127:0] key, input bit push);
    exp_t e;
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    if (push) begin
      model(key, e.rk);
      e.rcyc = cyc + 41;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (key_ready_f) return;
    end
    check("ready_timeout", 128'(key_ready_f), 128'd1);
  endtask

  // Monitor: on each rising key_ready, pop the expectation and sweep the read port.
  initial begin : monitor
    exp_t e;
    logic prev_ready = 1'b0;
    logic [127:0] wf, wr;
    rd_round_m = 4'd0;
    forever begin
      @(negedge clk);
      if (key_ready_f && !prev_ready) begin
        if (q.size() == 0) begin
          check("unexpected_ready", 128'd1, 128'd0);
        end else begin
          e = q.pop_front();
          check("ready_cycle", 128'(cyc), 128'(e.rcyc));
          check("ready_rev", 128'(key_ready_r), 128'd1);
          for (int r = 0; r < 16; r++) begin
            rd_round_m = 4'(r);
            #1;
            wf = (r <= 10) ? e.rk[r*128 +: 128] : 128'd0;
            wr = (r <= 10) ? e.rk[(10-r)*128 +: 128] : 128'd0;
            check($sformatf("fwd_rk%0d", r), rd_key_f, wf);
            check($sformatf("rev_rk%0d", r), rd_key_r, wr);
          end
          rd_round_m = 4'd0;
        end
      end
      prev_ready = key_ready_f;
    end
  end

  initial begin : stimulus
    logic [1407:0] rk;
    logic [127:0]  rkey;
    rst_n = 1'b0; start = 1'b0; key_in = '0; rst_chk = 1'b0; rd_round_r = 4'd0;
    build_sbox();

    model(128'h000102030405060708090a0b0c0d0e0f, rk);
    if (rk[128 +: 128] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe ||
        rk[1280 +: 128] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      $display("FAIL model_fips: got %h", rk[1280 +: 128]);
      $fatal(1, "reference model broken");
    end

    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy_f), 128'd0);
    check("rst_ready", 128'(key_ready_f), 128'd0);
    check("rst_rdkey", rd_key_f, 128'd0);
    rst_n = 1'b1;

    // FIPS-197 key, then restart from DONE with the second key.
    do_start(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    wait_ready();
    repeat (2) @(negedge clk);
    do_start(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    check("restart_ready_drop", 128'(key_ready_f), 128'd0);
    check("restart_busy", 128'(busy_f), 128'd1);
    wait_ready();

    // Start while busy is ignored.
    do_start({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    repeat (18) @(negedge clk);
    do_start({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    check("busy_after_ignored_start", 128'(busy_f), 128'd1);
    wait_ready();

    // Reset in the middle of an expansion.
    repeat (2) @(negedge clk);
    do_start({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_busy", 128'(busy_f), 128'd0);
    check("midrst_ready", 128'({key_ready_f, key_ready_r}), 128'd0);
    rst_chk = 1'b1;
    for (int r = 0; r <= 10; r++) begin
      rd_round_r = 4'(r);
      #1;
      check($sformatf("midrst_rd%0d", r), rd_key_f | rd_key_r, 128'd0);
    end
    rst_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_start(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    wait_ready();

    // Random keys, alternating immediate restart and a pause in DONE.
    for (int n = 0; n < 28; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      if (n % 2 == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
      do_start(rkey, 1'b1);
      wait_ready();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 128'(q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Upstream stage of the AES-128 round datapath: expands the 128-bit cipher key into all 11 round keys (44 words, FIPS-197) and holds them in a register file.
- Datapath requests any round key by index through a combinational read port.
- Replaces on-the-fly per-round key generation, so the datapath can start only after `key_ready` and read keys in forward or reverse (decryption) order.

Parameters:
- REVERSE, 0: 0 → `rd_round` r returns round key r; 1 → returns round key 10−r (inverse-cipher order).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latch `key_in` and begin expansion
- key_in  in  128  cipher key, byte 0 in [127:120]
- rd_round  in  4  round index 0..10 for the read port
- rd_key  out  128  selected round key, combinational from storage
- busy  out  1  expansion in progress
- key_ready  out  1  all 44 words valid

Behaviour:
- Reset (async, rst_n=0):
  - all 44 storage words = 0;
  - word counter = 0;
  - `busy` = 0; `key_ready` = 0; FSM → IDLE.
  - `rd_key` therefore reads 0.
- FSM states: IDLE, EXPAND, DONE.
- IDLE + start:
  - w0..w3 ← key_in (w0 = [127:96]);
  - counter i ← 4; busy ← 1; key_ready ← 0; → EXPAND.
- EXPAND: one word per cycle.
  - t = w[i−1].
  - If i mod 4 == 0: t = SubWord(RotWord(t)) XOR {Rcon[i/4], 24'h0}.
  - Rcon sequence 01,02,04,08,10,20,40,80,1b,36.
  - w[i] ← w[i−4] XOR t; i ← i+1.
  - After writing w43: busy ← 0, key_ready ← 1, → DONE.
- Latency: start sampled at edge E; w[i] written at edge E+i−3; key_ready high after edge E+40.
- S-box: local 256-entry forward table (function), 4 instances for SubWord; pure combinational.
- `start` handling by state:
  - While busy: ignored; the expansion in progress completes unchanged.
  - In DONE: restarts as from IDLE (new key latched); key_ready drops at that same edge.
- Read port:
  - rd_key = {w[4k], w[4k+1], w[4k+2], w[4k+3]}, with k = rd_round (REVERSE=0) or 10−rd_round (REVERSE=1).
  - rd_round > 10 → rd_key = 0.
  - Valid data is guaranteed only while key_ready = 1.
  - During EXPAND, rd_key shows partial contents; the consumer must not use them.
- Reset mid-expansion: immediate clear per reset values above; no partial key survives.
- Storage holds its value in DONE indefinitely; no change without a new start.

Test Plan:
- Reset values: assert rst_n=0 mid-simulation → busy=0, key_ready=0, rd_key=0 for rd_round 0..10, asynchronously, without waiting for a clk edge.
- FIPS-197 key, REVERSE=0: start with key 000102030405060708090a0b0c0d0e0f.
  - key_ready exactly 40 cycles after start edge.
  - rd_round 0 → 000102030405060708090a0b0c0d0e0f.
  - rd_round 1 → d6aa74fdd2af72fadaa678f1d6ab76fe.
  - rd_round 10 → 13111d7fe3944a17f307a78b4d2b30c5.
- Second key: key 2b7e151628aed2a6abf7158809cf4f3c → rd_round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- REVERSE=1, same FIPS-197 key:
  - rd_round 0 → 13111d7fe3944a17f307a78b4d2b30c5;
  - rd_round 10 → 000102...0f;
  - rd_round 12 → 0.
- Start while busy: pulse start with a different key at cycle 20 → ignored; final keys match the first key; key_ready still at cycle 40.
- Restart from DONE and mid-run reset:
  - start new key in DONE → key_ready=0 next cycle, re-asserts 40 cycles later with new keys.
  - rst_n low at cycle 15 → all outputs 0; a fresh start after release → correct keys.
